// File: rtl/vram_bus_bridge_pkg.sv
// Shared types and constants for the CPU-side VRAM bus bridge.
package vram_bus_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DONE_ERR
  } state_t;

  localparam logic [26:0] VRAM_BASE_ADDR = 27'h400000;
  localparam int          VRAM32_WORDS   = 1152;
  localparam int          VRAM8_WORDS    = 1792;
  localparam int          BANK_VRAM32    = 0;
  localparam int          BANK_VRAM8     = 1;

  // Bank-select width; a single bank still needs a 1-bit select.
  function automatic int sel_width(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/vram_addr_decode.sv
// Combinational bus-address decode into {valid, bank select, bank offset}.
module vram_addr_decode
  import vram_bus_bridge_pkg::*;
#(
  parameter int                BUS_AW     = 27,
  parameter int                NUM_BANKS  = 2,
  parameter int                BANK_AW    = 11,
  parameter int                BANK_WORDS = 2048,
  parameter logic [BUS_AW-1:0] BASE_ADDR  = BUS_AW'(VRAM_BASE_ADDR),
  localparam int               SEL_W      = sel_width(NUM_BANKS)
) (
  input  logic [BUS_AW-1:0]  bus_addr,
  output logic               valid,
  output logic [SEL_W-1:0]   sel,
  output logic [BANK_AW-1:0] idx
);

  localparam int HI_W = BUS_AW - BANK_AW;

  logic [BUS_AW-1:0] off;
  logic [HI_W-1:0]   hi;

  assign off = bus_addr - BASE_ADDR;
  assign hi  = off[BUS_AW-1:BANK_AW];
  assign idx = off[BANK_AW-1:0];
  assign sel = hi[SEL_W-1:0];

  // The explicit lower-bound test keeps a wrapped subtraction from aliasing onto a bank.
  assign valid = (bus_addr >= BASE_ADDR)
              && (hi < HI_W'(NUM_BANKS))
              && ({1'b0, idx} < (BANK_AW+1)'(BANK_WORDS));

endmodule

// File: rtl/vram_bus_bridge.sv
// CPU access port for all VRAM banks: one outstanding request, start/done handshake.
//
// state       | meaning
// ST_IDLE     | waiting for bus_start
// ST_WRITE    | vram_we pulse on the selected bank
// ST_READ     | waiting out the RAM read latency
// ST_DONE_ERR | address outside all banks, report error
module vram_bus_bridge
  import vram_bus_bridge_pkg::*;
#(
  parameter int                BUS_AW     = 27,
  parameter int                DATA_W     = 32,
  parameter int                NUM_BANKS  = 2,
  parameter int                BANK_AW    = 11,
  parameter int                BANK_WORDS = 2048,
  parameter logic [BUS_AW-1:0] BASE_ADDR  = BUS_AW'(VRAM_BASE_ADDR),
  parameter int                RD_LAT     = 1,
  localparam int               SEL_W      = sel_width(NUM_BANKS)
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          bus_start,
  input  logic                          bus_we,
  input  logic [BUS_AW-1:0]             bus_addr,
  input  logic [DATA_W-1:0]             bus_data,
  output logic [DATA_W-1:0]             bus_q,
  output logic                          bus_done,
  output logic                          bus_err,
  output logic                          busy,
  output logic [BANK_AW-1:0]            vram_addr,
  output logic [DATA_W-1:0]             vram_d,
  output logic [NUM_BANKS-1:0]          vram_we,
  input  logic [NUM_BANKS*DATA_W-1:0]   vram_q
);

  localparam int CNT_W = 2;

  state_t state, state_nxt;

  logic               dec_valid;
  logic [SEL_W-1:0]   dec_sel;
  logic [BANK_AW-1:0] dec_idx;

  logic [SEL_W-1:0]     sel_q, sel_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BANK_AW-1:0]   addr_nxt;
  logic [DATA_W-1:0]    d_nxt, q_nxt;
  logic [NUM_BANKS-1:0] we_nxt;
  logic                 done_nxt, err_nxt;

  logic [DATA_W-1:0] bank_q [NUM_BANKS];

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank_q
    assign bank_q[g] = vram_q[g*DATA_W +: DATA_W];
  end

  vram_addr_decode #(
    .BUS_AW     (BUS_AW),
    .NUM_BANKS  (NUM_BANKS),
    .BANK_AW    (BANK_AW),
    .BANK_WORDS (BANK_WORDS),
    .BASE_ADDR  (BASE_ADDR)
  ) u_decode (
    .bus_addr (bus_addr),
    .valid    (dec_valid),
    .sel      (dec_sel),
    .idx      (dec_idx)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      cnt       <= '0;
      vram_addr <= '0;
      vram_d    <= '0;
      vram_we   <= '0;
      bus_q     <= '0;
      bus_done  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel_q     <= sel_nxt;
      cnt       <= cnt_nxt;
      vram_addr <= addr_nxt;
      vram_d    <= d_nxt;
      vram_we   <= we_nxt;
      bus_q     <= q_nxt;
      bus_done  <= done_nxt;
      bus_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    cnt_nxt   = cnt;
    addr_nxt  = vram_addr;
    d_nxt     = vram_d;
    we_nxt    = '0;
    q_nxt     = bus_q;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus_start) begin
          if (!dec_valid) begin
            state_nxt = ST_DONE_ERR;
          end else if (bus_we) begin
            state_nxt       = ST_WRITE;
            addr_nxt        = dec_idx;
            d_nxt           = bus_data;
            we_nxt[dec_sel] = 1'b1;
          end else begin
            state_nxt = ST_READ;
            addr_nxt  = dec_idx;
            sel_nxt   = dec_sel;
            cnt_nxt   = CNT_W'(RD_LAT);
          end
        end
      end
      ST_WRITE: begin
        state_nxt = ST_IDLE;
        done_nxt  = 1'b1;
      end
      ST_READ: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
          q_nxt     = bank_q[sel_q];
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_DONE_ERR: begin
        state_nxt = ST_IDLE;
        q_nxt     = '0;
        done_nxt  = 1'b1;
        err_nxt   = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_vram_bus_bridge.sv
// Directed vector bench for vram_bus_bridge with a four-bank VRAM model (bank 1 is 8 bits wide).
module tb_vram_bus_bridge;

  localparam logic [26:0] BASE = 27'h400000;

  logic         clk;
  logic         nreset;
  logic         bus_start;
  logic         bus_we;
  logic [26:0]  bus_addr;
  logic [31:0]  bus_data;
  logic [31:0]  bus_q;
  logic         bus_done;
  logic         bus_err;
  logic         busy;
  logic [10:0]  vram_addr;
  logic [31:0]  vram_d;
  logic [3:0]   vram_we;
  logic [127:0] vram_q;

  vram_bus_bridge #(
    .NUM_BANKS  (4),
    .BANK_WORDS (1792),
    .RD_LAT     (2)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .bus_start (bus_start),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_data  (bus_data),
    .bus_q     (bus_q),
    .bus_done  (bus_done),
    .bus_err   (bus_err),
    .busy      (busy),
    .vram_addr (vram_addr),
    .vram_d    (vram_d),
    .vram_we   (vram_we),
    .vram_q    (vram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: synchronous RAM with a two-stage read pipeline.
  logic [31:0] mem [4][2048];
  logic [31:0] pipe1 [4];
  logic [31:0] pipe2 [4];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (vram_we[b]) mem[b][vram_addr] <= (b == 1) ? {24'h0, vram_d[7:0]} : vram_d;
      pipe1[b] <= mem[b][vram_addr];
      pipe2[b] <= pipe1[b];
    end
  end

  always_comb begin
    vram_q = '0;
    for (int b = 0; b < 4; b++) vram_q[b*32 +: 32] = pipe2[b];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic access(input logic we, input logic [26:0] addr, input logic [31:0] data,
                        output int edges, output logic err, output logic [31:0] q,
                        output logic [3:0] we_or, output int we_cyc,
                        output logic [10:0] a0, output logic [31:0] d0);
    @(negedge clk);
    bus_start = 1'b1; bus_we = we; bus_addr = addr; bus_data = data;
    @(posedge clk); #1;
    bus_start = 1'b0;
    a0 = vram_addr; d0 = vram_d; we_or = vram_we; we_cyc = (vram_we != 4'h0) ? 1 : 0;
    edges = 0;
    while (!bus_done && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      we_or |= vram_we;
      if (vram_we != 4'h0) we_cyc++;
    end
    err = bus_err; q = bus_q;
  endtask

  typedef struct {
    logic        we;
    logic [26:0] addr;
    logic [31:0] data;
    logic        err;
    logic [31:0] q;
    int          lat;
    logic [3:0]  wem;
    logic [10:0] idx;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          edges, we_cyc, dn, stray;
    logic        err;
    logic [31:0] q, d0, exp_d;
    logic [3:0]  we_or;
    logic [10:0] a0;
    logic [26:0] sw_addr [64];
    logic [31:0] ref_mem [logic [26:0]];

    vecs[0]  = '{1'b1, BASE + 27'h005,  32'hDEADBEEF, 1'b0, 32'h0,        1, 4'b0001, 11'h005};
    vecs[1]  = '{1'b1, BASE + 27'h810,  32'h123456A5, 1'b0, 32'h0,        1, 4'b0010, 11'h010};
    vecs[2]  = '{1'b0, BASE + 27'h810,  32'h0,        1'b0, 32'h000000A5, 3, 4'b0000, 11'h0};
    vecs[3]  = '{1'b0, BASE + 27'h005,  32'h0,        1'b0, 32'hDEADBEEF, 3, 4'b0000, 11'h0};
    vecs[4]  = '{1'b0, BASE - 27'h1,    32'h0,        1'b1, 32'h0,        1, 4'b0000, 11'h0};
    vecs[5]  = '{1'b0, BASE + 27'h810,  32'h0,        1'b0, 32'h000000A5, 3, 4'b0000, 11'h0};
    vecs[6]  = '{1'b1, BASE + 27'h2000, 32'h77777777, 1'b1, 32'h0,        1, 4'b0000, 11'h0};
    vecs[7]  = '{1'b1, BASE + 27'h700,  32'h66666666, 1'b1, 32'h0,        1, 4'b0000, 11'h0};
    vecs[8]  = '{1'b1, BASE + 27'h1EFF, 32'hCAFEF00D, 1'b0, 32'h0,        1, 4'b1000, 11'h6FF};
    vecs[9]  = '{1'b1, BASE + 27'h1123, 32'h0F0F1234, 1'b0, 32'h0,        1, 4'b0100, 11'h123};
    vecs[10] = '{1'b0, BASE + 27'h1EFF, 32'h0,        1'b0, 32'hCAFEF00D, 3, 4'b0000, 11'h0};
    vecs[11] = '{1'b0, BASE + 27'h1123, 32'h0,        1'b0, 32'h0F0F1234, 3, 4'b0000, 11'h0};
    vecs[12] = '{1'b0, 27'h0,           32'h0,        1'b1, 32'h0,        1, 4'b0000, 11'h0};
    vecs[13] = '{1'b1, BASE + 27'h6FF,  32'h11111111, 1'b0, 32'h0,        1, 4'b0001, 11'h6FF};
    vecs[14] = '{1'b0, BASE + 27'h6FF,  32'h0,        1'b0, 32'h11111111, 3, 4'b0000, 11'h0};

    nreset = 1'b0; bus_start = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_data = '0;
    #1;
    chk("rst_done", {31'h0, bus_done}, 32'h0);
    chk("rst_err",  {31'h0, bus_err},  32'h0);
    chk("rst_busy", {31'h0, busy},     32'h0);
    chk("rst_we",   {28'h0, vram_we},  32'h0);
    chk("rst_q",    bus_q,             32'h0);
    chk("rst_addr", {21'h0, vram_addr}, 32'h0);
    chk("rst_d",    vram_d,            32'h0);
    #20;
    @(negedge clk) nreset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].data, edges, err, q, we_or, we_cyc, a0, d0);
      chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].err});
      chk($sformatf("v%0d_lat", i), edges, vecs[i].lat);
      chk($sformatf("v%0d_we", i), {28'h0, we_or}, {28'h0, vecs[i].wem});
      chk($sformatf("v%0d_wecyc", i), we_cyc, (vecs[i].wem != 4'h0) ? 1 : 0);
      if (vecs[i].we && !vecs[i].err) begin
        chk($sformatf("v%0d_addr", i), {21'h0, a0}, {21'h0, vecs[i].idx});
        chk($sformatf("v%0d_d", i), d0, vecs[i].data);
      end else begin
        chk($sformatf("v%0d_q", i), q, vecs[i].q);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), {31'h0, bus_done}, 32'h0);
    end

    // Reset asserted while a write pulse is on the bus.
    @(negedge clk);
    bus_start = 1'b1; bus_we = 1'b1; bus_addr = BASE + 27'h005; bus_data = 32'hAAAA5555;
    @(posedge clk); #1;
    bus_start = 1'b0;
    chk("mid_we_pre", {28'h0, vram_we}, 32'h1);
    #2 nreset = 1'b0;
    #1;
    chk("mid_we",   {28'h0, vram_we}, 32'h0);
    chk("mid_done", {31'h0, bus_done}, 32'h0);
    chk("mid_busy", {31'h0, busy},     32'h0);
    chk("mid_q",    bus_q,             32'h0);
    @(negedge clk) nreset = 1'b1;
    @(posedge clk); #1;
    chk("mid_idle", {31'h0, busy}, 32'h0);
    access(1'b0, BASE + 27'h005, 32'h0, edges, err, q, we_or, we_cyc, a0, d0);
    chk("mid_rd_q", q, 32'hDEADBEEF);

    // Start pulsed while a read is in flight must be dropped.
    @(negedge clk);
    bus_start = 1'b1; bus_we = 1'b0; bus_addr = BASE + 27'h810;
    @(posedge clk); #1;
    bus_start = 1'b0;
    @(negedge clk);
    bus_start = 1'b1; bus_we = 1'b1; bus_addr = BASE + 27'h005; bus_data = 32'h0;
    @(posedge clk); #1;
    bus_start = 1'b0;
    dn = bus_done; we_or = vram_we;
    repeat (8) begin
      @(posedge clk); #1;
      dn += bus_done;
      we_or |= vram_we;
    end
    chk("busy_ign_dones", dn, 1);
    chk("busy_ign_we", {28'h0, we_or}, 32'h0);
    chk("busy_ign_q", bus_q, 32'h000000A5);

    // Start held through the done cycle starts a second access immediately.
    @(negedge clk);
    bus_start = 1'b1; bus_we = 1'b1; bus_addr = BASE + 27'h1123; bus_data = 32'h5A5A5A5A;
    @(posedge clk); #1;
    dn = bus_done;
    @(posedge clk); #1;
    dn += bus_done;
    chk("b2b_first_done", {31'h0, bus_done}, 32'h1);
    @(posedge clk); #1;
    dn += bus_done;
    chk("b2b_second_busy", {31'h0, busy}, 32'h1);
    bus_start = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      dn += bus_done;
    end
    chk("b2b_dones", dn, 2);

    // Random write/read-back sweep across all four banks.
    stray = 0;
    for (int i = 0; i < 64; i++) begin
      int unsigned sel, idx;
      logic [31:0] data;
      sel  = $urandom_range(0, 3);
      idx  = $urandom_range(0, 1791);
      data = $urandom;
      sw_addr[i] = 27'(32'h400000 + sel * 2048 + idx);
      ref_mem[sw_addr[i]] = (sel == 1) ? {24'h0, data[7:0]} : data;
      access(1'b1, sw_addr[i], data, edges, err, q, we_or, we_cyc, a0, d0);
      if (err || we_or != 4'(1 << sel) || we_cyc != 1) stray++;
    end
    for (int i = 0; i < 64; i++) begin
      access(1'b0, sw_addr[i], 32'h0, edges, err, q, we_or, we_cyc, a0, d0);
      exp_d = ref_mem[sw_addr[i]];
      chk($sformatf("sweep%0d_q", i), q, exp_d);
      if (err || we_or != 4'h0) stray++;
    end
    chk("sweep_stray", stray, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
